edge_det_filt: RTL and testbench

Parametrised multi-channel edge detector for asynchronous control and status inputs. Each channel has a configurable synchroniser chain and a programmable glitch filter. The block produces single-cycle rising, falling and mode-qualified edge pulses, plus a saturating per-channel edge counter. It sits between raw board and FPGA inputs and the PAM4/RGB control logic, and replaces fixed 3-bit, two-register edge detection.

---
 rtl/edge_det_pkg.sv | 24 ++
 rtl/edge_det_chan.sv | 70 +++++++
 rtl/edge_det_filt.sv | 44 ++++
 tb/tb_edge_det_filt.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// Shared mode encodings and edge-qualify helper for the edge detector channels.
// Pure definitions: no state, no latency, no flow control.
package edge_det_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    function automatic logic edge_qualify(input logic [1:0] mode,
                                          input logic       rise,
                                          input logic       fall);
        logic q;
        q = 1'b0;
        case (mode)
            MODE_RISE: q = rise;
            MODE_FALL: q = fall;
            MODE_BOTH: q = rise | fall;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One channel: synchroniser, glitch filter, registered edge pulses, saturating edge counter.
// Latency SYNC_STAGES+1+filt_len cycles from a stable input change; no backpressure.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [1:0]        mode,
    input  logic              clr_cnt,
    output logic              level_out,
    output logic              rising_edge,
    output logic              falling_edge,
    output logic              edge_pulse,
    output logic [CNT_W-1:0]  edge_cnt
);

    logic [SYNC_STAGES-1:0] sync;
    logic [FILT_W-1:0]      fcnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], data_in};
        end
    end

    // fcnt only advances while below filt_len, so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt         <= '0;
            level_out    <= 1'b0;
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
        end else begin
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
            if (s == level_out) begin
                fcnt <= '0;
            end else if (fcnt >= filt_len) begin
                level_out    <= s;
                fcnt         <= '0;
                rising_edge  <= s;
                falling_edge <= ~s;
            end else begin
                fcnt <= fcnt + FILT_W'(1);
            end
        end
    end

    assign edge_pulse = edge_qualify(mode, rising_edge, falling_edge);

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            edge_cnt <= '0;
        end else if (edge_pulse && (edge_cnt != '1)) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/edge_det_filt.sv
// Multi-channel filtered edge detector: fans shared controls out to CH independent channels.
// Latency SYNC_STAGES+1+filt_len cycles per channel; no backpressure.
module edge_det_filt
    import edge_det_pkg::*;
#(
    parameter int CH          = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       data_in,
    input  logic [FILT_W-1:0]   filt_len,
    input  logic [1:0]          mode,
    input  logic                clr_cnt,
    output logic [CH-1:0]       level_out,
    output logic [CH-1:0]       rising_edge,
    output logic [CH-1:0]       falling_edge,
    output logic [CH-1:0]       edge_pulse,
    output logic [CH*CNT_W-1:0] edge_cnt
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .data_in      (data_in[i]),
            .filt_len     (filt_len),
            .mode         (mode),
            .clr_cnt      (clr_cnt),
            .level_out    (level_out[i]),
            .rising_edge  (rising_edge[i]),
            .falling_edge (falling_edge[i]),
            .edge_pulse   (edge_pulse[i]),
            .edge_cnt     (edge_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_det_filt.sv
// Randomised and directed bench for edge_det_filt against a cycle-level reference model.
module tb_edge_det_filt;

    localparam int CH = 3;
    localparam int SS = 2;
    localparam int FW = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       data_in;
    logic [FW-1:0]       filt_len;
    logic [1:0]          mode;
    logic                clr_cnt;
    logic [CH-1:0]       level_out;
    logic [CH-1:0]       rising_edge;
    logic [CH-1:0]       falling_edge;
    logic [CH-1:0]       edge_pulse;
    logic [CH*CW-1:0]    edge_cnt;

    always #5 clk = ~clk;

    edge_det_filt #(
        .CH (CH), .SYNC_STAGES (SS), .FILT_W (FW), .CNT_W (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .filt_len     (filt_len),
        .mode         (mode),
        .clr_cnt      (clr_cnt),
        .level_out    (level_out),
        .rising_edge  (rising_edge),
        .falling_edge (falling_edge),
        .edge_pulse   (edge_pulse),
        .edge_cnt     (edge_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pipe holds the last SS sampled inputs (front = what the filter sees);
    // run counts consecutive cycles the synchronised input has disagreed with the level.
    int pipe [CH][$];
    int m_lvl  [CH];
    int m_run  [CH];
    int m_rise [CH];
    int m_fall [CH];
    int m_cnt  [CH];

    function automatic int wanted(int r, int f, logic [1:0] m);
        case (m)
            2'b00:   return r;
            2'b01:   return f;
            2'b10:   return (r != 0 || f != 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        int s;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                pipe[c].delete();
                for (int k = 0; k < SS; k++) pipe[c].push_back(0);
                m_lvl[c] = 0; m_run[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_cnt[c] = 0;
            end else begin
                if (clr_cnt) m_cnt[c] = 0;
                else if (wanted(m_rise[c], m_fall[c], mode) != 0 && m_cnt[c] < CMAX) m_cnt[c]++;
                s = pipe[c][0];
                m_rise[c] = 0;
                m_fall[c] = 0;
                if (s == m_lvl[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c]++;
                    if (m_run[c] >= int'(filt_len) + 1) begin
                        m_lvl[c]  = s;
                        m_rise[c] = s;
                        m_fall[c] = 1 - s;
                        m_run[c]  = 0;
                    end
                end
                void'(pipe[c].pop_front());
                pipe[c].push_back(int'(data_in[c]));
            end
        end
    endtask

    task automatic compare_all();
        logic [CH-1:0]    el, er, ef, ep;
        logic [CH*CW-1:0] ec;
        for (int c = 0; c < CH; c++) begin
            el[c] = (m_lvl[c] != 0);
            er[c] = (m_rise[c] != 0);
            ef[c] = (m_fall[c] != 0);
            ep[c] = (wanted(m_rise[c], m_fall[c], mode) != 0);
            ec[c*CW +: CW] = CW'(m_cnt[c]);
        end
        chk("level", level_out, el);
        chk("rise", rising_edge, er);
        chk("fall", falling_edge, ef);
        chk("pulse", edge_pulse, ep);
        chk("cnt", edge_cnt, ec);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; data_in = '0; filt_len = '0; mode = 2'b00; clr_cnt = 1'b0;
        steps(2);
        chk("reset_level", level_out, 0);
        chk("reset_cnt", edge_cnt, 0);

        // Basic latency: filt_len=0, rising edge seen after edge 3.
        rst = 1'b0; data_in = 3'b001;
        steps(2);
        chk("lat_e2_rise", rising_edge[0], 1'b0);
        step();
        chk("lat_e3_level", level_out[0], 1'b1);
        chk("lat_e3_rise", rising_edge[0], 1'b1);
        step();
        chk("lat_e4_rise", rising_edge[0], 1'b0);
        chk("lat_cnt0", edge_cnt[0 +: CW], 1);

        // Glitch filter on ch1 with filt_len=3.
        filt_len = 4'd3;
        data_in[1] = 1'b1; steps(3);
        data_in[1] = 1'b0; steps(10);
        chk("glitch_level1", level_out[1], 1'b0);
        data_in[1] = 1'b1; steps(4);
        data_in[1] = 1'b0; step();
        chk("filt_e5_rise1", rising_edge[1], 1'b0);
        step();
        chk("filt_e6_rise1", rising_edge[1], 1'b1);
        steps(12);

        // Both edges qualified on ch2, then mode off.
        filt_len = 4'd0; mode = 2'b10; clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        data_in[2] = 1'b1; steps(10);
        data_in[2] = 1'b0; steps(10);
        chk("both_cnt2", edge_cnt[2*CW +: CW], 2);
        mode = 2'b11;
        data_in[2] = 1'b1; steps(3);
        chk("off_rise2", rising_edge[2], 1'b1);
        chk("off_pulse2", edge_pulse[2], 1'b0);
        steps(7);
        data_in[2] = 1'b0; steps(10);
        chk("off_cnt2", edge_cnt[2*CW +: CW], 2);

        // Saturation on ch0, then clear colliding with a qualified edge.
        mode = 2'b10;
        for (int i = 0; i < 17; i++) begin
            data_in[0] = ~data_in[0];
            steps(4);
        end
        steps(4);
        chk("sat_cnt0", edge_cnt[0 +: CW], CMAX);
        data_in[0] = ~data_in[0];
        steps(3);
        chk("clr_pulse0", edge_pulse[0], 1'b1);
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        chk("clr_cnt0", edge_cnt[0 +: CW], 0);
        data_in = '0; steps(20);

        // Reset while ch0 filter count is at 2 of 3.
        filt_len = 4'd3; mode = 2'b00;
        data_in[0] = 1'b1; steps(4);
        rst = 1'b1; data_in[0] = 1'b0; step();
        chk("rstmid_level", level_out, 0);
        chk("rstmid_rise", rising_edge, 0);
        chk("rstmid_cnt", edge_cnt, 0);
        rst = 1'b0; steps(10);
        chk("rstmid_after", level_out[0], 1'b0);

        // Simultaneous rise on every channel.
        filt_len = 4'd0;
        data_in = '1; steps(3);
        chk("simul_rise", rising_edge, {CH{1'b1}});
        step();
        for (int c = 0; c < CH; c++) chk("simul_cnt", edge_cnt[c*CW +: CW], 1);
        data_in = '0; steps(6);

        // Random traffic with occasional control changes.
        for (int cyc = 0; cyc < 2500; cyc++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) data_in[c] = ~data_in[c];
            if ($urandom_range(0, 63) == 0) filt_len = FW'($urandom_range(0, 4) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            clr_cnt = ($urandom_range(0, 99) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
